// File: rtl/inst_loader.sv
// Streams a length-prefixed byte image into the instruction RAM while holding the CPU.
// Protocol: 16-bit little-endian word count, then 4 little-endian bytes per word.
module inst_loader #(
    parameter int DEPTH = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] LP_DEPTH = 16'(DEPTH);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_len;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_idx;
    logic [31:0] r_word;

    logic        w_accept;
    logic        w_launch;
    logic [15:0] w_len_full;
    logic [15:0] w_idx_inc;

    assign w_accept   = i_byte_valid && o_byte_ready;
    assign w_launch   = i_start && !i_abort;
    assign w_len_full = {i_byte_in, r_len[7:0]};
    assign w_idx_inc  = r_word_idx + 16'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort dominates any byte acceptance in the loading states.
    always_comb begin
        w_next       = r_state;
        o_byte_ready = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = 32'd0;
        o_mem_wdata  = 32'd0;
        o_cpu_hold   = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) w_next = S_LEN0;
            end
            S_LEN0: begin
                o_byte_ready = 1'b1;
                o_cpu_hold   = 1'b1;
                if (i_abort)       w_next = S_ERR;
                else if (w_accept) w_next = S_LEN1;
            end
            S_LEN1: begin
                o_byte_ready = 1'b1;
                o_cpu_hold   = 1'b1;
                if (i_abort) begin
                    w_next = S_ERR;
                end else if (w_accept) begin
                    if (w_len_full == 16'd0)         w_next = S_DONE;
                    else if (w_len_full > LP_DEPTH)  w_next = S_ERR;
                    else                             w_next = S_DATA;
                end
            end
            S_DATA: begin
                o_byte_ready = 1'b1;
                o_cpu_hold   = 1'b1;
                if (i_abort)                                w_next = S_ERR;
                else if (w_accept && r_byte_idx == 2'd3)    w_next = S_WRITE;
            end
            S_WRITE: begin
                o_cpu_hold  = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = {14'd0, r_word_idx, 2'b00};
                o_mem_wdata = r_word;
                if (i_abort)                  w_next = S_ERR;
                else if (w_idx_inc == r_len)  w_next = S_DONE;
                else                          w_next = S_DATA;
            end
            S_DONE: begin
                o_done = 1'b1;
                if (w_launch) w_next = S_LEN0;
            end
            S_ERR: begin
                o_err      = 1'b1;
                o_cpu_hold = 1'b1;
                if (w_launch) w_next = S_LEN0;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len      <= 16'd0;
            r_word_idx <= 16'd0;
            r_byte_idx <= 2'd0;
            r_word     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (w_launch) begin
                        r_len      <= 16'd0;
                        r_word_idx <= 16'd0;
                        r_byte_idx <= 2'd0;
                        r_word     <= 32'd0;
                    end
                end
                S_LEN0: begin
                    if (w_accept && !i_abort) r_len[7:0] <= i_byte_in;
                end
                S_LEN1: begin
                    if (w_accept && !i_abort) r_len[15:8] <= i_byte_in;
                end
                S_DATA: begin
                    if (w_accept && !i_abort) begin
                        r_word[{r_byte_idx, 3'b000} +: 8] <= i_byte_in;
                        r_byte_idx                        <= r_byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_word_idx <= w_idx_inc;
                    r_byte_idx <= 2'd0;
                end
                default: ;
            endcase
        end
    end

endmodule
